// File: rtl/soc_bus_pkg.sv
// Shared SoC bus definitions: bus widths, bus word types and copy-engine states.
package soc_bus_pkg;

   localparam int unsigned BUS_ADDR_W = 17;
   localparam int unsigned BUS_DATA_W = 8;

   typedef logic [BUS_ADDR_W-1:0] bus_addr_t;
   typedef logic [BUS_DATA_W-1:0] bus_data_t;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WAIT,
      WR,
      FIN
   } copy_state_t;

endpackage

// File: rtl/bus_copy_engine.sv
// Byte-wise bus copy engine: a second bus initiator that reads one byte from
// the source range, waits READ_LAT cycles for the responder, then writes it to
// the destination range. Ascending order; pointers wrap modulo 2^ADDR_W.
module bus_copy_engine
   import soc_bus_pkg::*;
#(
   parameter int unsigned ADDR_W   = BUS_ADDR_W,
   parameter int unsigned DATA_W   = BUS_DATA_W,
   parameter int unsigned READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_we,
   output logic [DATA_W-1:0] bus_data_out,
   input  logic [DATA_W-1:0] bus_data_in
);

   localparam int unsigned REM_W  = ADDR_W + 1;
   localparam int unsigned WCNT_W = 3;

   copy_state_t         state_q;
   logic [ADDR_W-1:0]   src_ptr_q;
   logic [ADDR_W-1:0]   dst_ptr_q;
   logic [REM_W-1:0]    rem_q;
   logic [WCNT_W-1:0]   wait_q;
   logic                busy_q;
   logic                done_q;
   logic [ADDR_W-1:0]   bus_addr_q;
   logic                bus_we_q;
   logic [DATA_W-1:0]   bus_data_out_q;

   logic [ADDR_W-1:0]   src_ptr_d;
   logic [ADDR_W-1:0]   dst_ptr_d;
   logic [REM_W-1:0]    rem_d;

   // Post-write pointer and remaining-count values, used when leaving WR.
   always_comb begin
      src_ptr_d = src_ptr_q + ADDR_W'(1);
      dst_ptr_d = dst_ptr_q + ADDR_W'(1);
      rem_d     = rem_q - REM_W'(1);
   end

   // Copy FSM; bus outputs are registered and set on entry to each state.
   // The write-data register doubles as the byte buffer captured in WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         src_ptr_q      <= '0;
         dst_ptr_q      <= '0;
         rem_q          <= '0;
         wait_q         <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         bus_addr_q     <= '0;
         bus_we_q       <= 1'b0;
         bus_data_out_q <= '0;
      end else begin
         done_q   <= 1'b0;
         bus_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               bus_addr_q <= '0;
               if (start) begin
                  if (len != '0) begin
                     src_ptr_q  <= src_addr;
                     dst_ptr_q  <= dst_addr;
                     rem_q      <= len;
                     bus_addr_q <= src_addr;
                     busy_q     <= 1'b1;
                     state_q    <= RD;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= FIN;
                  end
               end
            end
            RD: begin
               wait_q  <= WCNT_W'(READ_LAT);
               state_q <= WAIT;
            end
            WAIT: begin
               if (wait_q == WCNT_W'(1)) begin
                  bus_data_out_q <= bus_data_in;
                  bus_addr_q     <= dst_ptr_q;
                  bus_we_q       <= 1'b1;
                  state_q        <= WR;
               end else begin
                  wait_q <= wait_q - WCNT_W'(1);
               end
            end
            WR: begin
               src_ptr_q <= src_ptr_d;
               dst_ptr_q <= dst_ptr_d;
               rem_q     <= rem_d;
               if (rem_d == '0) begin
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  bus_addr_q <= '0;
                  state_q    <= FIN;
               end else begin
                  bus_addr_q <= src_ptr_d;
                  state_q    <= RD;
               end
            end
            FIN: begin
               state_q <= IDLE;
            end
            default: begin
               busy_q     <= 1'b0;
               bus_addr_q <= '0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign bus_addr     = bus_addr_q;
   assign bus_we       = bus_we_q;
   assign bus_data_out = bus_data_out_q;

endmodule

// File: tb/tb_bus_copy_engine.sv
// Testbench for bus_copy_engine: two instances (READ_LAT=1 and READ_LAT=3)
// each attached to a byte memory responder; expected writes and done pulses
// are queued when a copy is launched and compared as the DUT produces them.
module tb_bus_copy_engine;

   localparam int unsigned MEM_N = 131072;

   typedef struct {
      logic [16:0] a;
      logic [7:0]  d;
      int unsigned c;
   } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic        start1 = 1'b0, start3 = 1'b0;
   logic [16:0] src1 = '0, dst1 = '0, src3 = '0, dst3 = '0;
   logic [17:0] len1 = '0, len3 = '0;
   logic        busy1, done1, we1, busy3, done3, we3;
   logic [16:0] addr1, addr3;
   logic [7:0]  dout1, dout3;
   logic [7:0]  din1 = '0, din3 = '0;
   logic [7:0]  rd3_p0 = '0, rd3_p1 = '0;

   logic [7:0] mem1 [0:MEM_N-1];
   logic [7:0] mem3 [0:MEM_N-1];
   logic [7:0] ref1 [0:MEM_N-1];
   logic [7:0] ref3 [0:MEM_N-1];

   wr_t         wq1[$], wq3[$];
   int unsigned dq1[$], dq3[$];

   int unsigned ecnt = 0;
   int errors = 0;
   int checks = 0;
   int we_cnt1 = 0, busy_cnt1 = 0, done_cnt1 = 0;
   int we_cnt3 = 0, busy_cnt3 = 0, done_cnt3 = 0;

   bus_copy_engine #(.READ_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1),
      .src_addr(src1), .dst_addr(dst1), .len(len1),
      .busy(busy1), .done(done1),
      .bus_addr(addr1), .bus_we(we1), .bus_data_out(dout1), .bus_data_in(din1)
   );

   bus_copy_engine #(.READ_LAT(3)) u_dut3 (
      .clk(clk), .reset(reset), .start(start3),
      .src_addr(src3), .dst_addr(dst3), .len(len3),
      .busy(busy3), .done(done3),
      .bus_addr(addr3), .bus_we(we3), .bus_data_out(dout3), .bus_data_in(din3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ecnt <= ecnt + 1;

   // Responder for the READ_LAT=1 instance: one-cycle registered read.
   always @(posedge clk) begin
      din1 <= mem1[addr1];
      if (we1) mem1[addr1] <= dout1;
   end

   // Responder for the READ_LAT=3 instance: three-stage read pipeline.
   always @(posedge clk) begin
      rd3_p0 <= mem3[addr3];
      rd3_p1 <= rd3_p0;
      din3   <= rd3_p1;
      if (we3) mem3[addr3] <= dout3;
   end

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, ecnt);
      end
   endtask

   // Scoreboard consumers for both instances.
   always @(negedge clk) begin
      wr_t e;
      if (!reset) begin
         if (we1) begin
            we_cnt1++;
            check("we1_while_busy", busy1, 1);
            if (wq1.size() == 0) check("wr1_unexpected", 1, 0);
            else begin
               e = wq1.pop_front();
               check("wr1_addr", addr1, e.a);
               check("wr1_data", dout1, e.d);
               check("wr1_cycle", ecnt, e.c);
            end
         end
         if (busy1) busy_cnt1++;
         if (done1) begin
            done_cnt1++;
            if (dq1.size() == 0) check("done1_unexpected", 1, 0);
            else check("done1_cycle", ecnt, dq1.pop_front());
         end
         if (we3) begin
            we_cnt3++;
            check("we3_while_busy", busy3, 1);
            if (wq3.size() == 0) check("wr3_unexpected", 1, 0);
            else begin
               e = wq3.pop_front();
               check("wr3_addr", addr3, e.a);
               check("wr3_data", dout3, e.d);
               check("wr3_cycle", ecnt, e.c);
            end
         end
         if (busy3) busy_cnt3++;
         if (done3) begin
            done_cnt3++;
            if (dq3.size() == 0) check("done3_unexpected", 1, 0);
            else check("done3_cycle", ecnt, dq3.pop_front());
         end
      end
   end

   task automatic preload(input int which, input logic [16:0] a, input logic [7:0] d);
      if (which == 1) begin mem1[a] = d; ref1[a] = d; end
      else begin mem3[a] = d; ref3[a] = d; end
   endtask

   // Queue the expected writes (ascending, propagating overlaps) and done cycle.
   // Cycle c of a copy is sampled at the negedge where ecnt == base + c.
   task automatic plan_copy(input int which, input int unsigned lat,
                            input logic [16:0] src, input logic [16:0] dst,
                            input int unsigned n, input int unsigned base,
                            input int unsigned nwr, input bit with_done);
      wr_t e;
      logic [16:0] s, d;
      for (int unsigned k = 0; k < nwr; k++) begin
         s = src + 17'(k);
         d = dst + 17'(k);
         e.a = d;
         e.c = base + (lat + 2) * (k + 1);
         if (which == 1) begin e.d = ref1[s]; ref1[d] = e.d; wq1.push_back(e); end
         else begin e.d = ref3[s]; ref3[d] = e.d; wq3.push_back(e); end
      end
      if (with_done) begin
         if (which == 1) dq1.push_back(base + (lat + 2) * n + 1);
         else dq3.push_back(base + (lat + 2) * n + 1);
      end
   endtask

   // Called at a negedge; pulses start for one edge. Returns in cycle 1.
   task automatic start_copy(input int which, input logic [16:0] src,
                             input logic [16:0] dst, input logic [17:0] n,
                             output int unsigned base);
      base = ecnt;
      if (which == 1) begin src1 = src; dst1 = dst; len1 = n; start1 = 1'b1; end
      else begin src3 = src; dst3 = dst; len3 = n; start3 = 1'b1; end
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic wait_drain(input int which);
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 400 && !idle; i++) begin
         @(negedge clk);
         if (which == 1) idle = (wq1.size() == 0) && (dq1.size() == 0) && !busy1;
         else idle = (wq3.size() == 0) && (dq3.size() == 0) && !busy3;
      end
      check("drain_timeout", idle, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned b;
      int we0, busy0, done0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy1", busy1, 0);
      check("rst_done1", done1, 0);
      check("rst_we1", we1, 0);
      check("rst_addr1", addr1, 0);
      check("rst_dout1", dout1, 0);
      check("rst_busy3", busy3, 0);
      check("rst_we3", we3, 0);
      check("rst_addr3", addr3, 0);
      reset = 1'b0;
      @(negedge clk);

      // 1: basic 4-byte copy
      preload(1, 17'h100, 8'hAA); preload(1, 17'h101, 8'hBB);
      preload(1, 17'h102, 8'hCC); preload(1, 17'h103, 8'hDD);
      we0 = we_cnt1; done0 = done_cnt1;
      plan_copy(1, 1, 17'h100, 17'h200, 4, ecnt, 4, 1'b1);
      start_copy(1, 17'h100, 17'h200, 18'd4, b);
      check("t1_busy_c1", busy1, 1);
      check("t1_addr_c1", addr1, 17'h100);
      wait_drain(1);
      check("t1_we_pulses", we_cnt1 - we0, 4);
      check("t1_done_pulses", done_cnt1 - done0, 1);
      check("t1_mem200", mem1[17'h200], 8'hAA);
      check("t1_mem201", mem1[17'h201], 8'hBB);
      check("t1_mem202", mem1[17'h202], 8'hCC);
      check("t1_mem203", mem1[17'h203], 8'hDD);

      // 2: zero-length copy
      we0 = we_cnt1; busy0 = busy_cnt1; done0 = done_cnt1;
      plan_copy(1, 1, 17'h0, 17'h0, 0, ecnt, 0, 1'b1);
      start_copy(1, 17'h100, 17'h300, 18'd0, b);
      wait_drain(1);
      check("t2_we_pulses", we_cnt1 - we0, 0);
      check("t2_busy_cycles", busy_cnt1 - busy0, 0);
      check("t2_done_pulses", done_cnt1 - done0, 1);

      // 3: source and destination wrap / cross 0x0FFFF
      preload(1, 17'h1FFFF, 8'h11); preload(1, 17'h00000, 8'h22); preload(1, 17'h00001, 8'h33);
      plan_copy(1, 1, 17'h1FFFF, 17'h0FFFE, 3, ecnt, 3, 1'b1);
      start_copy(1, 17'h1FFFF, 17'h0FFFE, 18'd3, b);
      check("t3_addr_c1", addr1, 17'h1FFFF);
      repeat (3) @(negedge clk);
      check("t3_addr_c4_wrap", addr1, 17'h00000);
      wait_drain(1);
      check("t3_mem0FFFE", mem1[17'h0FFFE], 8'h11);
      check("t3_mem0FFFF", mem1[17'h0FFFF], 8'h22);
      check("t3_mem10000", mem1[17'h10000], 8'h33);

      // 4: READ_LAT=3 instance
      preload(3, 17'h2000, 8'h5A); preload(3, 17'h2001, 8'h5B);
      plan_copy(3, 3, 17'h2000, 17'h3000, 2, ecnt, 2, 1'b1);
      start_copy(3, 17'h2000, 17'h3000, 18'd2, b);
      check("t4_addr_rd", addr3, 17'h2000);
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         check("t4_addr_wait", addr3, 17'h2000);
         check("t4_we_wait", we3, 0);
      end
      wait_drain(3);
      check("t4_mem3000", mem3[17'h3000], 8'h5A);
      check("t4_mem3001", mem3[17'h3001], 8'h5B);

      // 5: reset in cycle 5 of a 4-byte copy
      preload(1, 17'h900, 8'h91); preload(1, 17'h901, 8'h92);
      preload(1, 17'h902, 8'h93); preload(1, 17'h903, 8'h94);
      for (int i = 0; i < 4; i++) preload(1, 17'hA00 + 17'(i), 8'hEE);
      done0 = done_cnt1;
      plan_copy(1, 1, 17'h900, 17'hA00, 4, ecnt, 1, 1'b0);
      start_copy(1, 17'h900, 17'hA00, 18'd4, b);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t5_busy", busy1, 0);
      check("t5_we", we1, 0);
      check("t5_done", done1, 0);
      check("t5_addr", addr1, 0);
      check("t5_dout", dout1, 0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check("t5_no_done", done_cnt1 - done0, 0);
      check("t5_wq_empty", wq1.size(), 0);
      check("t5_memA00", mem1[17'hA00], 8'h91);
      check("t5_memA01", mem1[17'hA01], 8'hEE);

      // 6: start ignored while busy; start held through FIN accepted in IDLE
      preload(1, 17'h300, 8'h31); preload(1, 17'h301, 8'h32);
      preload(1, 17'h500, 8'h51); preload(1, 17'h501, 8'h52);
      preload(1, 17'h700, 8'h71); preload(1, 17'h701, 8'h72);
      preload(1, 17'h800, 8'h08); preload(1, 17'h801, 8'h08);
      done0 = done_cnt1;
      plan_copy(1, 1, 17'h300, 17'h400, 2, ecnt, 2, 1'b1);
      plan_copy(1, 1, 17'h500, 17'h600, 2, ecnt + 8, 2, 1'b1);
      start_copy(1, 17'h300, 17'h400, 18'd2, b);
      @(negedge clk);                       // cycle 2
      src1 = 17'h700; dst1 = 17'h800; len1 = 18'd2; start1 = 1'b1;
      @(negedge clk);                       // cycle 3
      start1 = 1'b0;
      @(negedge clk);                       // cycle 4
      start1 = 1'b1;
      @(negedge clk);                       // cycle 5
      src1 = 17'h500; dst1 = 17'h600; len1 = 18'd2;
      repeat (4) @(negedge clk);            // cycle 9
      start1 = 1'b0;
      wait_drain(1);
      check("t6_done_pulses", done_cnt1 - done0, 2);
      check("t6_mem400", mem1[17'h400], 8'h31);
      check("t6_mem401", mem1[17'h401], 8'h32);
      check("t6_mem600", mem1[17'h600], 8'h51);
      check("t6_mem601", mem1[17'h601], 8'h52);
      check("t6_mem800", mem1[17'h800], 8'h08);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
